// File: rtl/toggle_request_round_robin_arbiter.sv
// Round-robin arbiter for clients using two-phase (toggle) request encoding.
// A client is pending while its request toggle differs from its acknowledge
// toggle. Grants go out on a registered valid/ready port, and each accepted
// grant flips that client's acknowledge bit.
// Optional feature: define TOGGLE_REQUEST_ROUND_ROBIN_ARBITER_BACK_TO_BACK_EN
// to re-arbitrate at the accepting edge (one grant per cycle sustained)
// instead of inserting an idle bubble after every acceptance.
module toggle_request_round_robin_arbiter #(
    parameter  int REQUESTERS  = 4,
    localparam int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [REQUESTERS-1:0]  request_toggle,
    output logic [REQUESTERS-1:0]  acknowledge_toggle,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic [REQUESTERS-1:0]  grant_onehot,
    input  logic                   grant_ready
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_q;
    logic [REQUESTERS-1:0]  ack_q;
    logic [REQUESTERS-1:0]  onehot_q;
    logic                   valid_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [INDEX_WIDTH-1:0] ptr_q;

    logic [REQUESTERS-1:0]  pending;
    logic [INDEX_WIDTH:0]   sel_idle_d;
    logic [INDEX_WIDTH-1:0] ptr_d;

    // First pending index at or above ptr, wrapping; MSB of result = found.
    function automatic logic [INDEX_WIDTH:0] rr_pick(
        input logic [REQUESTERS-1:0]  pend,
        input logic [INDEX_WIDTH-1:0] ptr
    );
        logic [INDEX_WIDTH:0] res;
        int                   j;
        res = '0;
        // Scan from the farthest offset down so the nearest pending one wins.
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= REQUESTERS) j = j - REQUESTERS;
            if (pend[j]) res = {1'b1, INDEX_WIDTH'(j)};
        end
        return res;
    endfunction

    function automatic logic [REQUESTERS-1:0] to_onehot(input logic [INDEX_WIDTH-1:0] idx);
        return {{(REQUESTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign pending    = request_toggle ^ ack_q;
    assign sel_idle_d = rr_pick(pending, ptr_q);
    // Pointer moves just past the accepted client, wrapping to zero.
    assign ptr_d      = (idx_q == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : idx_q + 1'b1;

`ifdef TOGGLE_REQUEST_ROUND_ROBIN_ARBITER_BACK_TO_BACK_EN
    logic [INDEX_WIDTH:0] sel_b2b_d;
    // The accepted client's bit is still pending this cycle, so mask it out.
    assign sel_b2b_d = rr_pick(pending & ~onehot_q, ptr_d);
`endif

    // Arbitration FSM with registered grant outputs and acknowledge toggles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            ptr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_idle_d[INDEX_WIDTH]) begin
                        idx_q    <= sel_idle_d[INDEX_WIDTH-1:0];
                        onehot_q <= to_onehot(sel_idle_d[INDEX_WIDTH-1:0]);
                        valid_q  <= 1'b1;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        ack_q[idx_q] <= ~ack_q[idx_q];
                        ptr_q        <= ptr_d;
`ifdef TOGGLE_REQUEST_ROUND_ROBIN_ARBITER_BACK_TO_BACK_EN
                        if (sel_b2b_d[INDEX_WIDTH]) begin
                            idx_q    <= sel_b2b_d[INDEX_WIDTH-1:0];
                            onehot_q <= to_onehot(sel_b2b_d[INDEX_WIDTH-1:0]);
                        end else begin
                            valid_q  <= 1'b0;
                            onehot_q <= '0;
                            state_q  <= IDLE;
                        end
`else
                        valid_q  <= 1'b0;
                        onehot_q <= '0;
                        state_q  <= IDLE;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign acknowledge_toggle = ack_q;
    assign grant_valid        = valid_q;
    assign grant_index        = idx_q;
    assign grant_onehot       = onehot_q;

endmodule

// File: tb/tb_toggle_request_round_robin_arbiter.sv
// Self-checking bench for toggle_request_round_robin_arbiter (REQUESTERS=4).
// Table-driven single-request vectors plus hand-written multi-cycle sequences;
// a scoreboard queue holds the expected grant order and is popped on acceptance.
module tb_toggle_request_round_robin_arbiter;

    localparam int R = 4;

    logic         clock = 1'b0;
    logic         resetn;
    logic [R-1:0] request_toggle;
    logic [R-1:0] acknowledge_toggle;
    logic         grant_valid;
    logic [1:0]   grant_index;
    logic [R-1:0] grant_onehot;
    logic         grant_ready;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    typedef struct {
        int         client;
        logic [3:0] onehot;
    } vec_t;

    vec_t vecs[4];

    toggle_request_round_robin_arbiter #(.REQUESTERS(R)) dut (
        .clock              (clock),
        .resetn             (resetn),
        .request_toggle     (request_toggle),
        .acknowledge_toggle (acknowledge_toggle),
        .grant_valid        (grant_valid),
        .grant_index        (grant_index),
        .grant_onehot       (grant_onehot),
        .grant_ready        (grant_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        request_toggle = '0;
        grant_ready    = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // Run until all requests are acknowledged and no grant is shown.
    task automatic wait_idle(input string name, input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!(grant_valid == 1'b0 && acknowledge_toggle == request_toggle) && cycles < budget);
        checks++;
        if (!(grant_valid == 1'b0 && acknowledge_toggle == request_toggle)) begin
            errors++;
            $display("FAIL %s_timeout: ack=%b req=%b valid=%b after %0d cycles",
                     name, acknowledge_toggle, request_toggle, grant_valid, cycles);
        end
    endtask

    // Scoreboard: grant_valid & grant_ready mid-cycle means acceptance at the next edge.
    always @(negedge clock) begin
        int e;
        if (resetn === 1'b1 && grant_valid === 1'b1 && grant_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got grant %0d expected none", grant_index);
            end else begin
                e = exp_q.pop_front();
                chk("sb_index", 32'(grant_index), 32'(e));
                chk("sb_onehot", 32'(grant_onehot), 32'(1) << e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        vecs[0] = '{2, 4'b0100};
        vecs[1] = '{0, 4'b0001};
        vecs[2] = '{3, 4'b1000};
        vecs[3] = '{1, 4'b0010};

        // Reset state, during and after reset
        resetn         = 1'b0;
        request_toggle = '0;
        grant_ready    = 1'b0;
        #1;
        chk("rst_valid", 32'(grant_valid), 0);
        chk("rst_ack", 32'(acknowledge_toggle), 0);
        chk("rst_onehot", 32'(grant_onehot), 0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_valid", 32'(grant_valid), 0);
        chk("post_rst_ack", 32'(acknowledge_toggle), 0);
        chk("post_rst_index", 32'(grant_index), 0);
        chk("post_rst_onehot", 32'(grant_onehot), 0);

        // Single-request vectors: grant one edge after the toggle, ack at acceptance
        grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vecs[i].client);
            request_toggle[vecs[i].client] = ~request_toggle[vecs[i].client];
            step();
            chk("vec_valid", 32'(grant_valid), 1);
            chk("vec_index", 32'(grant_index), 32'(vecs[i].client));
            chk("vec_onehot", 32'(grant_onehot), 32'(vecs[i].onehot));
            step();
            chk("vec_valid_drop", 32'(grant_valid), 0);
            chk("vec_onehot_drop", 32'(grant_onehot), 0);
            chk("vec_ack", 32'(acknowledge_toggle), 32'(request_toggle));
        end

        // All four at once from pointer 0: order 0,1,2,3
        do_reset();
        grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        request_toggle = 4'b1111;
        wait_idle("all4", 40, cyc);
`ifdef TOGGLE_REQUEST_ROUND_ROBIN_ARBITER_BACK_TO_BACK_EN
        chk("all4_cycles", 32'(cyc), 5);
`else
        chk("all4_cycles", 32'(cyc), 8);
`endif
        chk("all4_ack", 32'(acknowledge_toggle), 32'(4'b1111));

        // Grant held stable while ready is low, later request waits its turn
        grant_ready       = 1'b0;
        request_toggle[1] = ~request_toggle[1];
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(grant_valid), 1);
            chk("hold_index", 32'(grant_index), 1);
            chk("hold_onehot", 32'(grant_onehot), 32'(4'b0010));
            if (i == 1) request_toggle[3] = ~request_toggle[3];
            step();
        end
        chk("hold_ack_unchanged", 32'(acknowledge_toggle), 32'(4'b1111));
        exp_q.push_back(1);
        exp_q.push_back(3);
        grant_ready = 1'b1;
        step();
`ifdef TOGGLE_REQUEST_ROUND_ROBIN_ARBITER_BACK_TO_BACK_EN
        chk("hold_next_index", 32'(grant_index), 3);
`else
        chk("hold_bubble", 32'(grant_valid), 0);
        step();
        chk("hold_next_index", 32'(grant_index), 3);
`endif
        wait_idle("hold", 20, cyc);

        // Pointer wrapped to 0 after granting 3: requests 0 and 3 go 0 then 3
        exp_q.push_back(0);
        exp_q.push_back(3);
        request_toggle[0] = ~request_toggle[0];
        request_toggle[3] = ~request_toggle[3];
        wait_idle("wrap", 20, cyc);

        // Pointer past 2: requests 1 and 3 go 3 then 1
        exp_q.push_back(2);
        request_toggle[2] = ~request_toggle[2];
        wait_idle("ptr2", 20, cyc);
        exp_q.push_back(3);
        exp_q.push_back(1);
        request_toggle[1] = ~request_toggle[1];
        request_toggle[3] = ~request_toggle[3];
        wait_idle("ptr3", 20, cyc);
        chk("ptr_ack", 32'(acknowledge_toggle), 32'(4'b0010));

        // Reset while a grant on client 1 is outstanding
        grant_ready       = 1'b0;
        request_toggle[1] = ~request_toggle[1];
        step();
        chk("mid_valid", 32'(grant_valid), 1);
        chk("mid_index", 32'(grant_index), 1);
        #1;
        resetn         = 1'b0;
        request_toggle = '0;
        #1;
        chk("mid_rst_valid", 32'(grant_valid), 0);
        chk("mid_rst_ack", 32'(acknowledge_toggle), 0);
        chk("mid_rst_onehot", 32'(grant_onehot), 0);
        step();
        step();
        resetn      = 1'b1;
        grant_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_mid_valid", 32'(grant_valid), 0);
        end

        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
